// File: rtl/alu_seq.sv
// Sequencer for an external 4-bit ALU: registers operands, waits SETTLE cycles,
// captures the result into an accumulator and updates carry/zero flags.
module alu_seq #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       load,
  input  logic [2:0] op,
  input  logic [3:0] operand,
  input  logic       cin,
  input  logic       use_carry,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic       alu_c,
  output logic [2:0] alu_s,
  input  logic [3:0] alu_o,
  input  logic       alu_cout,
  output logic [3:0] acc,
  output logic       carry_flag,
  output logic       zero_flag,
  output logic       busy,
  output logic       done
);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  localparam logic [2:0] CNT_LAST = 3'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] acc_q, acc_d;
  logic       carry_q, carry_d;
  logic       zero_q, zero_d;
  logic       done_q, done_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic       alu_c_q, alu_c_d;
  logic [2:0] alu_s_q, alu_s_d;

  // Only ADD and shift produce a meaningful carry-out.
  function automatic logic op_sets_carry(input logic [2:0] sel);
    return (sel == 3'd1) || (sel == 3'd5);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    alu_a_d = alu_a_q;
    alu_b_d = alu_b_q;
    alu_c_d = alu_c_q;
    alu_s_d = alu_s_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (load) begin
            acc_d  = operand;
            zero_d = (operand == 4'h0);
            done_d = 1'b1;
          end else begin
            alu_a_d = acc_q;
            alu_b_d = operand;
            alu_s_d = op;
            alu_c_d = use_carry ? carry_q : cin;
            cnt_d   = 3'd0;
            state_d = EXEC;
          end
        end
      end

      EXEC: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == CNT_LAST) begin
          acc_d  = alu_o;
          zero_d = (alu_o == 4'h0);
          if (op_sets_carry(alu_s_q)) begin
            carry_d = alu_cout;
          end
          done_d  = 1'b1;
          cnt_d   = 3'd0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      acc_q   <= 4'h0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
      done_q  <= 1'b0;
      alu_a_q <= 4'h0;
      alu_b_q <= 4'h0;
      alu_c_q <= 1'b0;
      alu_s_q <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      alu_c_q <= alu_c_d;
      alu_s_q <= alu_s_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_c      = alu_c_q;
  assign alu_s      = alu_s_q;
  assign acc        = acc_q;
  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;
  assign done       = done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: two instances (SETTLE=1 and SETTLE=4), each driving a
// behavioural ALU; results are checked through a done-triggered scoreboard.
module tb_alu_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] acc;
    logic       c;
    logic       z;
    logic       busy;
    logic       done;
    logic [3:0] a;
    logic [3:0] b;
    logic       ac;
    logic [2:0] s;
  } obs_t;

  typedef struct packed {
    logic       ld;
    logic [2:0] op;
    logic [3:0] b;
    logic       ci;
    logic       uc;
    logic [3:0] acc;
    logic       c;
    logic       z;
  } vec_t;

  logic       rst0, start0, load0, cin0, uc0;
  logic [2:0] op0;
  logic [3:0] operand0;
  logic [3:0] alu_a0, alu_b0, alu_o0, acc0;
  logic [2:0] alu_s0;
  logic       alu_c0, alu_cout0, carry0, zero0, busy0, done0;

  logic       rst1, start1, load1, cin1, uc1;
  logic [2:0] op1;
  logic [3:0] operand1;
  logic [3:0] alu_a1, alu_b1, alu_o1, acc1;
  logic [2:0] alu_s1;
  logic       alu_c1, alu_cout1, carry1, zero1, busy1, done1;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt[2];
  logic [5:0] q0[$];
  logic [5:0] q1[$];
  logic [3:0] m_acc[2];
  logic       m_c[2];
  vec_t       vecs[15];

  alu_seq #(.SETTLE(1)) u_dut0 (
    .clk(clk), .rst(rst0), .start(start0), .load(load0), .op(op0),
    .operand(operand0), .cin(cin0), .use_carry(uc0),
    .alu_a(alu_a0), .alu_b(alu_b0), .alu_c(alu_c0), .alu_s(alu_s0),
    .alu_o(alu_o0), .alu_cout(alu_cout0), .acc(acc0), .carry_flag(carry0),
    .zero_flag(zero0), .busy(busy0), .done(done0)
  );

  alu_seq #(.SETTLE(4)) u_dut1 (
    .clk(clk), .rst(rst1), .start(start1), .load(load1), .op(op1),
    .operand(operand1), .cin(cin1), .use_carry(uc1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_c(alu_c1), .alu_s(alu_s1),
    .alu_o(alu_o1), .alu_cout(alu_cout1), .acc(acc1), .carry_flag(carry1),
    .zero_flag(zero1), .busy(busy1), .done(done1)
  );

  // Non-arithmetic ops drive a deliberately varying carry-out that must be ignored.
  function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic c, input logic [2:0] s);
    case (s)
      3'd0:    return {1'b1, ~a};
      3'd1:    return {1'b0, a} + {1'b0, b} + {4'h0, c};
      3'd2:    return {1'b1, a & b};
      3'd3:    return {1'b1, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {a, c};
      3'd6:    return {1'b1, 4'h0};
      default: return {1'b0, 4'hF};
    endcase
  endfunction

  assign {alu_cout0, alu_o0} = alu_model(alu_a0, alu_b0, alu_c0, alu_s0);
  assign {alu_cout1, alu_o1} = alu_model(alu_a1, alu_b1, alu_c1, alu_s1);

  function automatic obs_t obs(input int d);
    obs_t o;
    if (d == 0) o = {acc0, carry0, zero0, busy0, done0, alu_a0, alu_b0, alu_c0, alu_s0};
    else        o = {acc1, carry1, zero1, busy1, done1, alu_a1, alu_b1, alu_c1, alu_s1};
    return o;
  endfunction

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic st, input logic ld, input logic [2:0] o,
                       input logic [3:0] b, input logic ci, input logic uc);
    if (d == 0) begin
      start0 = st; load0 = ld; op0 = o; operand0 = b; cin0 = ci; uc0 = uc;
    end else begin
      start1 = st; load1 = ld; op1 = o; operand1 = b; cin1 = ci; uc1 = uc;
    end
  endtask

  task automatic push(input int d, input logic [5:0] e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic sb_pop(input int d);
    obs_t o;
    logic [5:0] e;
    int sz;
    o = obs(d);
    done_cnt[d]++;
    check("done_while_busy", o.busy, 0);
    sz = (d == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_done dut%0d: got done=1, expected no done", d);
    end else begin
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      check($sformatf("result dut%0d {acc,c,z}", d), {o.acc, o.c, o.z}, e);
    end
  endtask

  always @(negedge clk) begin
    if (done0 === 1'b1) sb_pop(0);
    if (done1 === 1'b1) sb_pop(1);
  end

  task automatic check_reset(input int d);
    obs_t o;
    o = obs(d);
    check($sformatf("rst_acc dut%0d", d), o.acc, 0);
    check($sformatf("rst_carry dut%0d", d), o.c, 0);
    check($sformatf("rst_zero dut%0d", d), o.z, 1);
    check($sformatf("rst_busy dut%0d", d), o.busy, 0);
    check($sformatf("rst_done dut%0d", d), o.done, 0);
    check($sformatf("rst_alu_abcs dut%0d", d), {o.a, o.b, o.ac, o.s}, 0);
  endtask

  task automatic issue(input int d, input vec_t v);
    int edges;
    obs_t o;
    logic exp_cin;
    logic [3:0] prev_acc;
    exp_cin  = v.uc ? m_c[d] : v.ci;
    prev_acc = m_acc[d];
    @(negedge clk);
    drive(d, 1'b1, v.ld, v.op, v.b, v.ci, v.uc);
    push(d, {v.acc, v.c, v.z});
    m_acc[d] = v.acc;
    m_c[d]   = v.c;
    @(posedge clk);
    #1;
    drive(d, 1'b0, v.ld, v.op, v.b, v.ci, v.uc);
    edges = 1;
    o = obs(d);
    if (v.ld) begin
      check("load_busy", o.busy, 0);
    end else begin
      check("exec_busy", o.busy, 1);
      check("exec_done_low", o.done, 0);
      check("exec_alu_a", o.a, prev_acc);
      check("exec_alu_b", o.b, v.b);
      check("exec_alu_c", o.ac, exp_cin);
      check("exec_alu_s", o.s, v.op);
    end
    while (!o.done && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      o = obs(d);
    end
    check($sformatf("latency dut%0d op%0d", d, v.op), edges, v.ld ? 1 : settle_of(d) + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    obs_t o;
    int   dn, first, edges, dbefore;

    vecs = '{
      '{1'b1, 3'd0, 4'h9, 1'b0, 1'b0, 4'h9, 1'b0, 1'b0},
      '{1'b0, 3'd1, 4'h8, 1'b1, 1'b0, 4'h2, 1'b1, 1'b0},
      '{1'b0, 3'd1, 4'h0, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0},
      '{1'b1, 3'd0, 4'h5, 1'b0, 1'b0, 4'h5, 1'b0, 1'b0},
      '{1'b0, 3'd6, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1},
      '{1'b1, 3'd0, 4'hF, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0},
      '{1'b0, 3'd1, 4'h1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1},
      '{1'b0, 3'd7, 4'h0, 1'b0, 1'b0, 4'hF, 1'b1, 1'b0},
      '{1'b0, 3'd2, 4'h6, 1'b0, 1'b0, 4'h6, 1'b1, 1'b0},
      '{1'b0, 3'd4, 4'h3, 1'b0, 1'b0, 4'h5, 1'b1, 1'b0},
      '{1'b0, 3'd5, 4'h0, 1'b0, 1'b0, 4'hA, 1'b0, 1'b0},
      '{1'b0, 3'd3, 4'h5, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0},
      '{1'b0, 3'd0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1},
      '{1'b1, 3'd0, 4'h8, 1'b0, 1'b0, 4'h8, 1'b0, 1'b0},
      '{1'b0, 3'd5, 4'h0, 1'b1, 1'b0, 4'h1, 1'b1, 1'b0}
    };

    done_cnt[0] = 0; done_cnt[1] = 0;
    m_acc[0] = 4'h0; m_acc[1] = 4'h0;
    m_c[0] = 1'b0;   m_c[1] = 1'b0;
    rst0 = 1'b1; rst1 = 1'b1;
    drive(0, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst0 = 1'b0;
    rst1 = 1'b0;

    // SETTLE=1 directed vectors
    for (int i = 0; i < 15; i++) issue(0, vecs[i]);

    // SETTLE=4: load, then start held high across EXEC and into the done cycle
    issue(1, '{1'b1, 3'd0, 4'h3, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0});
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 3'd1, 4'h2, 1'b0, 1'b0);
    push(1, {4'h5, 1'b0, 1'b0});
    m_acc[1] = 4'h5;
    dn = 0;
    first = 0;
    for (int e = 1; e <= 5; e++) begin
      @(posedge clk);
      #1;
      o = obs(1);
      if (o.done) begin
        dn++;
        first = e;
      end
    end
    check("held_start_done_count", dn, 1);
    check("held_start_done_edge", first, 5);
    push(1, {4'h7, 1'b0, 1'b0});
    m_acc[1] = 4'h7;
    @(posedge clk);
    #1;
    o = obs(1);
    check("done_cycle_start_busy", o.busy, 1);
    check("done_cycle_start_alu_a", o.a, 4'h5);
    drive(1, 1'b0, 1'b0, 3'd1, 4'h2, 1'b0, 1'b0);
    edges = 1;
    while (!o.done && edges < 40) begin
      @(posedge clk);
      #1;
      edges++;
      o = obs(1);
    end
    check("done_cycle_start_latency", edges, 5);

    // SETTLE=4: reset in the second EXEC cycle abandons the operation
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 3'd1, 4'h1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    drive(1, 1'b0, 1'b0, 3'd1, 4'h1, 1'b0, 1'b0);
    o = obs(1);
    check("abort_exec_busy", o.busy, 1);
    @(posedge clk);
    #1;
    rst1 = 1'b1;
    #1;
    check_reset(1);
    dbefore = done_cnt[1];
    repeat (2) @(negedge clk);
    rst1 = 1'b0;
    drive(1, 1'b1, 1'b1, 3'd0, 4'h6, 1'b0, 1'b0);
    push(1, {4'h6, 1'b0, 1'b0});
    m_acc[1] = 4'h6;
    m_c[1] = 1'b0;
    @(posedge clk);
    #1;
    drive(1, 1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 1'b0);
    o = obs(1);
    check("first_edge_load_acc", o.acc, 4'h6);
    check("first_edge_load_done", o.done, 1);
    repeat (8) @(posedge clk);
    #1;
    check("abort_done_count", done_cnt[1] - dbefore, 1);

    check("pending_dut0", q0.size(), 0);
    check("pending_dut1", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
